game_fsm_multi: RTL and testbench

Parametrised game-state controller for the stickman runner. It sits between the keyboard/frame counter and the background and colour-mapper blocks. Compared with the single-life 3-coin controller, it adds:
- N coins and a collected-coin score.
- Multiple lives, with a respawn sequence and grace frames.
- A pause mode and a freeze output for the scroller.
- Edge-detected keys and a frame tick synchronised to Clk.

---
 rtl/game_pkg.sv | 23 ++
 rtl/coin_hit.sv | 36 +++
 rtl/game_fsm_multi.sv | 194 +++++++++++++++++++
 tb/tb_game_fsm_multi.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the stickman runner game-state controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_PLAY    = 3'd1,
    S_RESPAWN = 3'd2,
    S_PAUSE   = 3'd3,
    S_WIN     = 3'd4,
    S_LOSE    = 3'd5
  } game_state_t;

  // Bit positions inside the one-hot status vector {wait, play, pause, win, lose}.
  localparam int ST_WAIT  = 4;
  localparam int ST_PLAY  = 3;
  localparam int ST_PAUSE = 2;
  localparam int ST_WIN   = 1;
  localparam int ST_LOSE  = 0;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

endpackage

// File: rtl/coin_hit.sv
// Combinational overlap test between one coin and the stickman hitbox.
module coin_hit #(
  parameter int FRAME_W  = 13,
  parameter int Y_W      = 10,
  parameter int STICK_X  = 100,
  parameter int HIT_X_LO = 10,
  parameter int HIT_X_HI = 46,
  parameter int HIT_Y_LO = 10,
  parameter int HIT_Y_HI = 74
) (
  input  logic [FRAME_W-1:0] frame_counter,
  input  logic [FRAME_W-1:0] coin_x,
  input  logic [Y_W-1:0]     stick_top,
  input  logic [Y_W-1:0]     coin_y,
  output logic               hit
);

  localparam int XW = FRAME_W + 1;
  localparam int YW = Y_W + 1;

  // One extra bit on every sum so the window edges never wrap.
  logic [XW-1:0] left, x_lo, x_hi, cx;
  logic [YW-1:0] y_lo, y_hi, cy;

  always_comb begin
    left = XW'(STICK_X) + {1'b0, frame_counter};
    x_lo = left + XW'(HIT_X_LO);
    x_hi = left + XW'(HIT_X_HI);
    cx   = {1'b0, coin_x};
    y_lo = {1'b0, stick_top} + YW'(HIT_Y_LO);
    y_hi = {1'b0, stick_top} + YW'(HIT_Y_HI);
    cy   = {1'b0, coin_y};
    hit  = (cx > x_lo) && (cx < x_hi) && (cy > y_lo) && (cy < y_hi);
  end

endmodule

// File: rtl/game_fsm_multi.sv
// Game-state controller: coins and score, multiple lives with respawn/grace,
// pause, and a scroller freeze output.
module game_fsm_multi
  import game_pkg::*;
#(
  parameter int NUM_COINS      = 3,
  parameter int FRAME_W        = 13,
  parameter int Y_W            = 10,
  parameter int NUM_LIVES      = 3,
  parameter int WIN_FRAME      = 3000,
  parameter int STICK_X        = 100,
  parameter int STICK_H        = 50,
  parameter int FLOOR_Y        = 470,
  parameter int HIT_X_LO       = 10,
  parameter int HIT_X_HI       = 46,
  parameter int HIT_Y_LO       = 10,
  parameter int HIT_Y_HI       = 74,
  parameter int RESPAWN_FRAMES = 60,
  parameter int GRACE_FRAMES   = 90
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic                               frame_clk,
  input  logic [7:0]                         keycode,
  input  logic [Y_W-1:0]                     StickmanTop,
  input  logic [Y_W-1:0]                     GroundY,
  input  logic [FRAME_W-1:0]                 frame_counter,
  input  logic [NUM_COINS-1:0][FRAME_W-1:0]  CoinFrameX,
  input  logic [NUM_COINS-1:0][Y_W-1:0]      CoinY,
  output logic [NUM_COINS-1:0]               CoinStatus,
  output logic [4:0]                         status,
  output logic [$clog2(NUM_COINS+1)-1:0]     score,
  output logic [$clog2(NUM_LIVES+1)-1:0]     lives,
  output logic                               freeze,
  output logic                               respawn_req,
  output game_state_t                        state_dbg
);

  localparam int SW = $clog2(NUM_COINS + 1);
  localparam int LW = $clog2(NUM_LIVES + 1);
  localparam int GW = $clog2(GRACE_FRAMES + 1);
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  game_state_t          state_q, state_d;
  logic [2:0]           fsync_q;
  logic [7:0]           key_prev_q;
  logic [NUM_COINS-1:0] coin_q, coin_d, hit;
  logic [SW-1:0]        score_q, score_d, gained;
  logic [SW:0]          score_sum;
  logic [LW-1:0]        lives_q, lives_d;
  logic [GW-1:0]        grace_q, grace_d;
  logic [RW-1:0]        resp_q, resp_d;
  logic                 freeze_q, freeze_d, req_q, req_d;
  logic                 frame_tick, start_edge, pause_edge;
  logic [Y_W:0]         feet;
  logic                 crash, fall, hazard;

  // fsync_q[1:0] is the synchroniser, fsync_q[2] the previous synchronised level.
  assign frame_tick = fsync_q[1] & ~fsync_q[2];
  assign start_edge = (keycode == KEY_SPACE) && (key_prev_q != KEY_SPACE);
  assign pause_edge = (keycode == KEY_P) && (key_prev_q != KEY_P);

  assign feet   = {1'b0, StickmanTop} + (Y_W+1)'(STICK_H);
  assign crash  = feet > {1'b0, GroundY};
  assign fall   = feet >= (Y_W+1)'(FLOOR_Y);
  assign hazard = fall | (crash & (grace_q == '0));

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_coin
    coin_hit #(
      .FRAME_W(FRAME_W), .Y_W(Y_W), .STICK_X(STICK_X),
      .HIT_X_LO(HIT_X_LO), .HIT_X_HI(HIT_X_HI),
      .HIT_Y_LO(HIT_Y_LO), .HIT_Y_HI(HIT_Y_HI)
    ) u_hit (
      .frame_counter(frame_counter),
      .coin_x       (CoinFrameX[i]),
      .stick_top    (StickmanTop),
      .coin_y       (CoinY[i]),
      .hit          (hit[i])
    );
  end

  always_comb begin
    gained = '0;
    for (int i = 0; i < NUM_COINS; i++) gained = gained + SW'(coin_q[i] & hit[i]);
    score_sum = {1'b0, score_q} + {1'b0, gained};
  end

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    score_d = score_q;
    lives_d = lives_q;
    grace_d = grace_q;
    resp_d  = resp_q;
    req_d   = 1'b0;
    case (state_q)
      S_WAIT: begin
        coin_d  = '1;
        score_d = '0;
        lives_d = LW'(NUM_LIVES);
        grace_d = '0;
        if (start_edge) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Coins are collected even on the cycle that leaves PLAY.
        coin_d  = coin_q & ~hit;
        score_d = (score_sum > (SW+1)'(NUM_COINS)) ? SW'(NUM_COINS) : score_sum[SW-1:0];
        if (frame_tick && grace_q != '0) grace_d = grace_q - 1'b1;
        if (hazard) begin
          if (lives_q <= LW'(1)) begin
            lives_d = '0;
            state_d = S_LOSE;
          end else begin
            lives_d = lives_q - 1'b1;
            req_d   = 1'b1;
            resp_d  = RW'(RESPAWN_FRAMES);
            state_d = S_RESPAWN;
          end
        end else if (frame_counter >= FRAME_W'(WIN_FRAME)) begin
          state_d = S_WIN;
        end else if (pause_edge) begin
          state_d = S_PAUSE;
        end
      end
      S_RESPAWN: begin
        if (resp_q == '0) begin
          grace_d = GW'(GRACE_FRAMES);
          state_d = S_PLAY;
        end else if (frame_tick) begin
          resp_d = resp_q - 1'b1;
        end
      end
      S_PAUSE: if (pause_edge) state_d = S_PLAY;
      S_WIN, S_LOSE: begin
        // Load the fresh-game values on the way out so WAIT shows them at once.
        if (start_edge) begin
          coin_d  = '1;
          score_d = '0;
          lives_d = LW'(NUM_LIVES);
          grace_d = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
    freeze_d = (state_d == S_PAUSE) || (state_d == S_RESPAWN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_WAIT;
      fsync_q    <= '0;
      key_prev_q <= '0;
      coin_q     <= '1;
      score_q    <= '0;
      lives_q    <= LW'(NUM_LIVES);
      grace_q    <= '0;
      resp_q     <= '0;
      freeze_q   <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fsync_q    <= {fsync_q[1:0], frame_clk};
      key_prev_q <= keycode;
      coin_q     <= coin_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      grace_q    <= grace_d;
      resp_q     <= resp_d;
      freeze_q   <= freeze_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    status = '0;
    case (state_q)
      S_WAIT:            status[ST_WAIT]  = 1'b1;
      S_PLAY, S_RESPAWN: status[ST_PLAY]  = 1'b1;
      S_PAUSE:           status[ST_PAUSE] = 1'b1;
      S_WIN:             status[ST_WIN]   = 1'b1;
      S_LOSE:            status[ST_LOSE]  = 1'b1;
      default:           status = '0;
    endcase
  end

  assign CoinStatus  = coin_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign freeze      = freeze_q;
  assign respawn_req = req_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_fsm_multi.sv
// Bench for game_fsm_multi: directed game scenarios, hitbox/hazard tables and
// randomized play against a rule-level reference model.
module tb_game_fsm_multi;
  import game_pkg::*;

  localparam int MW_WAIT = 0, MW_PLAY = 1, MW_RESP = 2, MW_PAUSE = 3, MW_WIN = 4, MW_LOSE = 5;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_clk = 1'b0;
  logic [7:0]        keycode = 8'h00;
  logic [9:0]        top = 10'd200;
  logic [9:0]        ground = 10'd400;
  logic [12:0]       fcnt = 13'd200;
  logic [2:0][12:0]  cx = '0;
  logic [2:0][9:0]   cy = '0;
  logic [2:0]        coin_status;
  logic [4:0]        status;
  logic [1:0]        score, lives;
  logic              freeze, respawn_req;
  game_state_t       state_dbg;

  game_fsm_multi dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .StickmanTop(top), .GroundY(ground), .frame_counter(fcnt),
    .CoinFrameX(cx), .CoinY(cy), .CoinStatus(coin_status), .status(status),
    .score(score), .lives(lives), .freeze(freeze), .respawn_req(respawn_req),
    .state_dbg(state_dbg)
  );

  always #10 Clk = ~Clk;

  int checks = 0, errors = 0, cyc = 0, req_seen = 0;
  bit fc_en = 1'b0;

  // Reference model state
  int m_mode, m_score, m_lives, m_grace, m_resp;
  bit [2:0] m_coins;
  bit m_req, m_freeze;
  logic [7:0] m_prev;
  bit fc_h[3];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      if (errors < 40) $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int exp_status(input int mode);
    case (mode)
      MW_WAIT:          return 16;
      MW_PLAY, MW_RESP: return 8;
      MW_PAUSE:         return 4;
      MW_WIN:           return 2;
      default:          return 1;
    endcase
  endfunction

  function automatic bit ref_hit(input int i);
    int l;
    l = 100 + int'(fcnt);
    return (int'(cx[i]) > l + 10) && (int'(cx[i]) < l + 46) &&
           (int'(cy[i]) > int'(top) + 10) && (int'(cy[i]) < int'(top) + 74);
  endfunction

  task automatic model_reset();
    m_mode = MW_WAIT; m_score = 0; m_lives = 3; m_grace = 0; m_resp = 0;
    m_coins = 3'b111; m_req = 0; m_freeze = 0; m_prev = 8'h00;
    fc_h[0] = 0; fc_h[1] = 0; fc_h[2] = 0;
  endtask

  task automatic fresh_game();
    m_coins = 3'b111; m_score = 0; m_lives = 3; m_grace = 0;
  endtask

  task automatic model_step();
    bit tick, start, pause, crash, fall, hazard;
    int feet, got;
    tick  = fc_h[1] && !fc_h[2];
    fc_h[2] = fc_h[1]; fc_h[1] = fc_h[0]; fc_h[0] = frame_clk;
    start = (keycode == 8'h2C) && (m_prev != 8'h2C);
    pause = (keycode == 8'h13) && (m_prev != 8'h13);
    m_prev = keycode;
    feet  = int'(top) + 50;
    crash = feet > int'(ground);
    fall  = feet >= 470;
    m_req = 0;
    case (m_mode)
      MW_WAIT: begin
        fresh_game();
        if (start) m_mode = MW_PLAY;
      end
      MW_PLAY: begin
        hazard = fall || (crash && m_grace == 0);
        got = 0;
        for (int i = 0; i < 3; i++)
          if (m_coins[i] && ref_hit(i)) begin got++; m_coins[i] = 0; end
        m_score = (m_score + got > 3) ? 3 : m_score + got;
        if (tick && m_grace > 0) m_grace--;
        if (hazard) begin
          if (m_lives <= 1) begin m_lives = 0; m_mode = MW_LOSE; end
          else begin m_lives--; m_req = 1; m_resp = 60; m_mode = MW_RESP; end
        end else if (fcnt >= 3000) m_mode = MW_WIN;
        else if (pause) m_mode = MW_PAUSE;
      end
      MW_RESP: begin
        if (m_resp == 0) begin m_grace = 90; m_mode = MW_PLAY; end
        else if (tick) m_resp--;
      end
      MW_PAUSE: if (pause) m_mode = MW_PLAY;
      default: if (start) begin fresh_game(); m_mode = MW_WAIT; end
    endcase
    m_freeze = (m_mode == MW_PAUSE) || (m_mode == MW_RESP);
  endtask

  task automatic compare_all();
    chk("status", status, exp_status(m_mode));
    chk("coins", coin_status, int'(m_coins));
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    chk("freeze", freeze, int'(m_freeze));
    chk("respawn_req", respawn_req, int'(m_req));
  endtask

  task automatic step();
    if (fc_en) frame_clk = cyc[1];
    model_step();
    @(posedge Clk);
    #1;
    cyc++;
    if (respawn_req === 1'b1) req_seen++;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic wait_freeze(input bit val, input int budget, input string name);
    int n = 0;
    while (freeze !== val && n < budget) begin step(); n++; end
    chk(name, freeze, int'(val));
  endtask

  task automatic press(input logic [7:0] key);
    keycode = 8'h00; step();
    keycode = key;   step();
  endtask

  typedef struct { int dx; int dy; bit hit; } hit_vec_t;
  typedef struct { int top; int ground; int lives; } haz_vec_t;
  hit_vec_t hv[10];
  haz_vec_t zv[6];

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    hv[0] = '{11, 40, 1}; hv[1] = '{10, 40, 0}; hv[2] = '{45, 40, 1}; hv[3] = '{46, 40, 0};
    hv[4] = '{20, 11, 1}; hv[5] = '{20, 10, 0}; hv[6] = '{20, 73, 1}; hv[7] = '{20, 74, 0};
    hv[8] = '{-5, 40, 0}; hv[9] = '{30, 100, 0};
    zv[0] = '{200, 250, 3}; zv[1] = '{200, 249, 2}; zv[2] = '{419, 600, 3};
    zv[3] = '{420, 600, 2}; zv[4] = '{0, 49, 2};    zv[5] = '{1000, 1023, 2};

    // 1: reset with space held, single start edge, held key gives nothing more
    keycode = 8'h2C;
    Reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_status", status, 16);
    chk("rst_lives", lives, 3);
    chk("rst_coins", coin_status, 7);
    chk("rst_freeze", freeze, 0);
    Reset_n = 1'b1;
    step();
    chk("start_play", status, 8);
    steps(5);
    chk("held_space", status, 8);

    // 2: coin 1 collected once
    cx[1] = 13'd320; cy[1] = 10'd240;
    step();
    chk("coin1_taken", coin_status, 5);
    chk("score_one", score, 1);
    steps(100);
    chk("score_held_overlap", score, 1);
    cx[1] = '0; cy[1] = '0;

    // 3: crash -> respawn, grace immunity, fall during grace
    fc_en = 1'b1;
    req_seen = 0;
    ground = 10'd249;
    step();
    chk("crash_lives", lives, 2);
    chk("crash_freeze", freeze, 1);
    wait_freeze(1'b0, 400, "respawn_done");
    chk("respawn_pulses", req_seen, 1);
    steps(200);
    chk("grace_no_loss", lives, 2);
    top = 10'd420;
    step();
    chk("fall_in_grace", lives, 1);

    // 4: last life lost by fall -> LOSE, then restart
    wait_freeze(1'b0, 400, "respawn2_done");
    step();
    chk("lose_status", status, 1);
    chk("lose_lives", lives, 0);
    chk("lose_score_held", score, 1);
    top = 10'd200; ground = 10'd400;
    press(8'h2C);
    chk("restart_status", status, 16);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_coins", coin_status, 7);

    // 5: pause freezes everything
    press(8'h2C);
    keycode = 8'h13; step();
    chk("pause_status", status, 4);
    chk("pause_freeze", freeze, 1);
    cx[1] = 13'd320; cy[1] = 10'd240; ground = 10'd249;
    steps(20);
    chk("pause_coins", coin_status, 7);
    chk("pause_lives", lives, 3);
    cx[1] = '0; cy[1] = '0; ground = 10'd400;
    press(8'h13);
    chk("unpause_status", status, 8);
    chk("unpause_freeze", freeze, 0);

    // 6: hazard beats win; win alone
    top = 10'd420;
    wait_freeze(1'b1, 10, "fall_a");
    wait_freeze(1'b0, 400, "resp_a");
    wait_freeze(1'b1, 10, "fall_b");
    chk("two_falls_lives", lives, 1);
    top = 10'd200;
    wait_freeze(1'b0, 400, "resp_b");
    steps(400);
    ground = 10'd249; fcnt = 13'd3000;
    step();
    chk("crash_over_win", status, 1);
    ground = 10'd400;
    press(8'h2C);
    press(8'h2C);
    step();
    chk("win_status", status, 2);
    press(8'h2C);
    fcnt = 13'd200;
    fc_en = 1'b0;

    // Hitbox boundary table
    foreach (hv[k]) begin
      keycode = 8'h2C;
      do_reset();
      step();
      fcnt = 13'($urandom_range(0, 2000));
      top  = 10'($urandom_range(100, 300));
      cx[0] = 13'(100 + int'(fcnt) + hv[k].dx);
      cy[0] = 10'(int'(top) + hv[k].dy);
      step();
      chk($sformatf("hit_vec%0d", k), coin_status[0], int'(!hv[k].hit));
      chk($sformatf("hit_score%0d", k), score, int'(hv[k].hit));
      cx[0] = '0; cy[0] = '0;
    end

    // Crash/fall boundary table
    foreach (zv[k]) begin
      keycode = 8'h2C; top = 10'd200; ground = 10'd400;
      do_reset();
      step();
      top = 10'(zv[k].top); ground = 10'(zv[k].ground);
      step();
      chk($sformatf("haz_vec%0d", k), lives, zv[k].lives);
    end

    // Randomized play against the model
    keycode = 8'h2C; top = 10'd200; ground = 10'd400; fcnt = 13'd200;
    do_reset();
    fc_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0)
        case ($urandom_range(0, 2))
          0: keycode = 8'h00;
          1: keycode = 8'h2C;
          default: keycode = 8'h13;
        endcase
      if ($urandom_range(0, 19) == 0) begin
        top = ($urandom_range(0, 99) < 15) ? 10'd430 : 10'($urandom_range(150, 250));
        ground = 10'(int'(top) + $urandom_range(45, 60));
        fcnt = ($urandom_range(0, 99) < 3) ? 13'($urandom_range(3000, 3050))
                                           : 13'($urandom_range(0, 2900));
        for (int i = 0; i < 3; i++) begin
          cx[i] = 13'(100 + int'(fcnt) + $urandom_range(5, 50));
          cy[i] = 10'(int'(top) + $urandom_range(5, 80));
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
